// File: rtl/dmem_arbiter.sv
// Data-memory arbiter/sequencer between the MEM-stage CPU port and a debug/loader port.
// Optional starvation guard for the debug port is enabled by defining DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [3:0]        dbg_be,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    DBG_ACK = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   dbg_rd;
  logic   dbg_rd_next;
  logic   dbg_grant;
  logic   cpu_grant;
  logic   starve_hit;

  // Byte offsets are the requester's concern; only word addresses reach memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], dbg_addr[1:0]};

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

  // Count CPU wins while debug is waiting; the counter never passes STARVE_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!dbg_req || dbg_grant) begin
      starve_cnt <= '0;
    end else if (cpu_grant) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= starve_cnt;
    end
  end
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign starve_hit = 1'b0;
`endif

  // Arbitration happens only in IDLE and never while reset is applied.
  always_comb begin
    dbg_grant = 1'b0;
    cpu_grant = 1'b0;
    if (!rst && (state == IDLE)) begin
      if (dbg_req && (!cpu_req || starve_hit)) begin
        dbg_grant = 1'b1;
      end else if (cpu_req) begin
        cpu_grant = 1'b1;
      end else begin
        dbg_grant = 1'b0;
        cpu_grant = 1'b0;
      end
    end else begin
      dbg_grant = 1'b0;
      cpu_grant = 1'b0;
    end
  end

  // State register plus the read/write flag of the debug access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dbg_rd <= 1'b0;
    end else begin
      state  <= state_next;
      dbg_rd <= dbg_rd_next;
    end
  end

  // Next state, memory drive and requester outputs; everything is forced low in reset.
  always_comb begin
    state_next  = state;
    dbg_rd_next = dbg_rd;
    cpu_rdata   = 32'd0;
    cpu_stall   = 1'b0;
    dbg_ack     = 1'b0;
    dbg_rdata   = 32'd0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'd0;
    mem_addr    = '0;
    mem_wdata   = 32'd0;
    if (rst) begin
      state_next  = IDLE;
      dbg_rd_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_grant) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_be    = cpu_be;
            mem_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = cpu_wdata;
            if (!cpu_we) begin
              cpu_stall  = 1'b1;
              state_next = CPU_RD;
            end else begin
              cpu_stall  = 1'b0;
              state_next = IDLE;
            end
          end else if (dbg_grant) begin
            mem_en      = 1'b1;
            mem_we      = dbg_we;
            mem_be      = dbg_be;
            mem_addr    = {dbg_addr[ADDR_W-1:2], 2'b00};
            mem_wdata   = dbg_wdata;
            cpu_stall   = cpu_req;
            dbg_rd_next = !dbg_we;
            state_next  = DBG_ACK;
          end else begin
            state_next = IDLE;
          end
        end
        CPU_RD: begin
          cpu_rdata  = mem_rdata;
          state_next = IDLE;
        end
        DBG_ACK: begin
          dbg_ack    = 1'b1;
          dbg_rdata  = dbg_rd ? mem_rdata : 32'd0;
          cpu_stall  = cpu_req;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a synchronous-read byte-lane memory model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [3:0]  cpu_be, dbg_be, mem_be;
  logic [31:0] cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        cpu_stall, dbg_ack, mem_en, mem_we;
  logic [31:0] mem [0:63];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem_rdata = 32'd0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_be = 4'hF; dbg_addr = 32'd0; dbg_wdata = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h10; dbg_req = 1'b1;
    tick(); tick(); #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0h want 0", cpu_stall); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en: got %0h want 0", mem_en); end
    n_cmp++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL rst_dbg_ack: got %0h want 0", dbg_ack); end
    n_cmp++; if (cpu_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_rdata); end
    n_cmp++; if (mem_addr !== 32'd0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    tick();
    rst = 1'b0; idle_inputs(); #1;
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL idle_mem_en: got %0h want 0", mem_en); end
  endtask

  task automatic test_store_load();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL st_stall: got %0h want 0", cpu_stall); end
    n_cmp++; if ({mem_en, mem_we} !== 2'b11) begin n_bad++; $display("FAIL st_mem_ctl: got %b want 11", {mem_en, mem_we}); end
    tick();
    cpu_we = 1'b0; cpu_addr = 32'h13; #1;
    n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL st_written: got %h want deadbeef", mem[4]); end
    n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL ld_stall: got %0h want 1", cpu_stall); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL ld_align: got %h want 10", mem_addr); end
    tick(); #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL ld_release: got %0h want 0", cpu_stall); end
    n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_data: got %h want deadbeef", cpu_rdata); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL ld_rd_mem_en: got %0h want 0", mem_en); end
    tick();
    cpu_req = 1'b0; #1;
    n_cmp++; if (cpu_rdata !== 32'd0) begin n_bad++; $display("FAIL rdata_idle: got %h want 0", cpu_rdata); end
  endtask

  task automatic test_debug();
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_be = 4'hF; dbg_addr = 32'h4; dbg_wdata = 32'h12345678; #1;
    n_cmp++; if ({mem_en, mem_we} !== 2'b11) begin n_bad++; $display("FAIL dw_mem_ctl: got %b want 11", {mem_en, mem_we}); end
    n_cmp++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL dw_early_ack: got %0h want 0", dbg_ack); end
    tick();
    dbg_req = 1'b0; #1;
    n_cmp++; if (dbg_ack !== 1'b1) begin n_bad++; $display("FAIL dw_ack: got %0h want 1", dbg_ack); end
    n_cmp++; if (dbg_rdata !== 32'd0) begin n_bad++; $display("FAIL dw_rdata: got %h want 0", dbg_rdata); end
    n_cmp++; if (mem[1] !== 32'h12345678) begin n_bad++; $display("FAIL dw_written: got %h want 12345678", mem[1]); end
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; #1;
    n_cmp++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL dw_ack_once: got %0h want 0", dbg_ack); end
    tick();
    dbg_req = 1'b0; #1;
    n_cmp++; if (dbg_ack !== 1'b1) begin n_bad++; $display("FAIL dr_ack: got %0h want 1", dbg_ack); end
    n_cmp++; if (dbg_rdata !== 32'h12345678) begin n_bad++; $display("FAIL dr_rdata: got %h want 12345678", dbg_rdata); end
  endtask

  task automatic test_byte_lanes();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h8; cpu_wdata = 32'd0;
    tick();
    cpu_be = 4'b0100; cpu_wdata = 32'hAABBCCDD; #1;
    n_cmp++; if (mem_be !== 4'b0100) begin n_bad++; $display("FAIL bl_be: got %b want 0100", mem_be); end
    tick();
    cpu_we = 1'b0; cpu_be = 4'hF;
    tick(); #1;
    n_cmp++; if (cpu_rdata !== 32'h00BB0000) begin n_bad++; $display("FAIL bl_data: got %h want 00bb0000", cpu_rdata); end
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic test_starvation();
    int first_ack = -1;
    int acks = 0;
    int stalls = 0;
    logic stall_at_ack = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; dbg_we = 1'b0; dbg_addr = 32'h4;
    for (int k = 0; k < 50; k++) begin
      if (k > 0) tick();
      if (k == 1) dbg_req = 1'b1;
      #1;
      if (cpu_stall) stalls++;
      if (dbg_ack) begin
        acks++;
        if (first_ack < 0) begin first_ack = k; stall_at_ack = cpu_stall; end
        dbg_req = 1'b0;
      end
    end
    tick();
    idle_inputs();
    tick();
`ifdef DMEM_ARB_FAIRNESS_EN
    n_cmp++; if (first_ack - 1 !== 18) begin n_bad++; $display("FAIL fair_ack_delay: got %0d want 18", first_ack - 1); end
    n_cmp++; if (stall_at_ack !== 1'b1) begin n_bad++; $display("FAIL fair_stall: got %0h want 1", stall_at_ack); end
`else
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL starve_acks: got %0d want 0", acks); end
    n_cmp++; if (stalls !== 25) begin n_bad++; $display("FAIL starve_stalls: got %0d want 25", stalls); end
`endif
  endtask

  task automatic test_back_to_back();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h20; cpu_wdata = 32'h11223344;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4; #1;
    n_cmp++; if (mem_addr !== 32'h20) begin n_bad++; $display("FAIL sim_cpu_first: got %h want 20", mem_addr); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL sim_st_stall: got %0h want 0", cpu_stall); end
    tick();
    cpu_req = 1'b0; #1;
    n_cmp++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h4}) begin n_bad++; $display("FAIL sim_dbg_grant: got %b/%h want 10/4", {mem_en, mem_we}, mem_addr); end
    tick();
    dbg_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; #1;
    n_cmp++; if (dbg_ack !== 1'b1) begin n_bad++; $display("FAIL sim_ack: got %0h want 1", dbg_ack); end
    n_cmp++; if (dbg_rdata !== 32'h12345678) begin n_bad++; $display("FAIL sim_rdata: got %h want 12345678", dbg_rdata); end
    n_cmp++; if ({cpu_stall, mem_en} !== 2'b10) begin n_bad++; $display("FAIL sim_ack_stall: got %b want 10", {cpu_stall, mem_en}); end
    tick(); #1;
    n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_stall1: got %0h want 1", cpu_stall); end
    tick(); #1;
    n_cmp++; if (cpu_rdata !== 32'h11223344) begin n_bad++; $display("FAIL b2b_data1: got %h want 11223344", cpu_rdata); end
    tick();
    cpu_addr = 32'h4; #1;
    n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_stall2: got %0h want 1", cpu_stall); end
    tick(); #1;
    n_cmp++; if (cpu_rdata !== 32'h12345678) begin n_bad++; $display("FAIL b2b_data2: got %h want 12345678", cpu_rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4; rst = 1'b1; #1;
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rm_mem_en_in_rst: got %0h want 0", mem_en); end
    tick();
    rst = 1'b0; dbg_req = 1'b0; #1;
    n_cmp++; if ({dbg_ack, cpu_stall, mem_en} !== 3'b000) begin n_bad++; $display("FAIL rm_after: got %b want 000", {dbg_ack, cpu_stall, mem_en}); end
    tick();
    dbg_req = 1'b1;
    tick();
    dbg_req = 1'b0; rst = 1'b1; #1;
    n_cmp++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL rm_ack_in_rst: got %0h want 0", dbg_ack); end
    tick();
    rst = 1'b0; #1;
    n_cmp++; if ({dbg_ack, cpu_stall, mem_en} !== 3'b000) begin n_bad++; $display("FAIL rm_discard: got %b want 000", {dbg_ack, cpu_stall, mem_en}); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_store_load();
    test_debug();
    test_byte_lanes();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
